// File: rtl/aes_line_sequencer.sv
// Streams 1024-bit memory lines through an AES core as eight 128-bit
// blocks and writes each reassembled result line back to memory.
module aes_line_sequencer #(
    parameter int ADDR_W    = 12,
    parameter int MEM_WORDS = 3601,
    parameter int LINE_W    = 1024,
    parameter int BLK_W     = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [ADDR_W-1:0]     num_lines,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [LINE_W/8-1:0]   mem_byteenable,
    output logic [LINE_W-1:0]     mem_writedata,
    input  logic [LINE_W-1:0]     mem_readdata,
    output logic                  mem_clken,
    output logic                  aes_in_valid,
    input  logic                  aes_in_ready,
    output logic [BLK_W-1:0]      aes_in_data,
    input  logic                  aes_out_valid,
    output logic                  aes_out_ready,
    input  logic [BLK_W-1:0]      aes_out_data
);

    localparam int LANES = LINE_W / BLK_W;
    localparam int CW    = $clog2(LANES + 1);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [CW-1:0] LAST_C  = CW'(LANES - 1);
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE, CHECK, RD_REQ, RD_WAIT, STREAM, WR, NEXT, FIN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   src_ptr;
    logic [ADDR_W-1:0]   dst_ptr;
    logic [ADDR_W-1:0]   remain;
    logic [LINE_W-1:0]   line_buf;
    logic [LINE_W-1:0]   res_buf;
    logic [CW-1:0]       in_cnt;
    logic [CW-1:0]       out_cnt;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                range_bad;
    logic                in_hs;
    logic                out_hs;
    logic [BLK_W-1:0]    lane_sel;

    // Range checks are done one bit wider so the sums cannot wrap.
    assign range_bad = (remain == '0)
        || (({1'b0, src_ptr} + {1'b0, remain}) > MEM_LIM)
        || (({1'b0, dst_ptr} + {1'b0, remain}) > MEM_LIM);

    assign in_hs  = aes_in_valid & aes_in_ready;
    assign out_hs = aes_out_valid & aes_out_ready;

    always_comb begin
        lane_sel = '0;
        for (int l = 0; l < LANES; l++) begin
            if (in_cnt == CW'(l)) lane_sel = line_buf[l*BLK_W +: BLK_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            remain   <= '0;
            line_buf <= '0;
            res_buf  <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        remain  <= num_lines;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (range_bad) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        state <= RD_REQ;
                    end
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    line_buf <= mem_readdata;
                    in_cnt   <= '0;
                    out_cnt  <= '0;
                    state    <= STREAM;
                end
                STREAM: begin
                    if (in_hs) in_cnt <= in_cnt + 1'b1;
                    if (out_hs) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (out_cnt == CW'(l))
                                res_buf[l*BLK_W +: BLK_W] <= aes_out_data;
                        end
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt == LAST_C) state <= WR;
                    end
                end
                WR: state <= NEXT;
                NEXT: begin
                    src_ptr <= src_ptr + 1'b1;
                    dst_ptr <= dst_ptr + 1'b1;
                    remain  <= remain - 1'b1;
                    if (remain == ADDR_W'(1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        state <= RD_REQ;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // busy also covers the cycle in which start is being accepted.
    assign busy = busy_q | ((state == IDLE) & start & reset_n);
    assign done = done_q;
    assign err  = err_q;

    assign mem_clken      = 1'b1;
    assign mem_chipselect = (state == RD_REQ) | (state == WR);
    assign mem_write      = (state == WR);
    assign mem_address    = (state == RD_REQ) ? src_ptr :
                            (state == WR)     ? dst_ptr : '0;
    assign mem_byteenable = {(LINE_W/8){mem_write}};
    assign mem_writedata  = mem_write ? res_buf : '0;

    assign aes_in_valid  = (state == STREAM) & (in_cnt < LANES_C);
    assign aes_in_data   = lane_sel;
    assign aes_out_ready = (state == STREAM) & (out_cnt < LANES_C);

endmodule

// File: tb/tb_aes_line_sequencer.sv
// Bench for aes_line_sequencer: line memory and XOR-ones AES core models
// with a sequential line-by-line reference image of expected memory.
module tb_aes_line_sequencer;

    localparam int AW = 12;
    localparam int NW = 3601;
    localparam int LW = 1024;
    localparam int BW = 128;
    localparam int LANES = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   src_addr = '0;
    logic [AW-1:0]   dst_addr = '0;
    logic [AW-1:0]   num_lines = '0;
    logic            busy, done, err;
    logic [AW-1:0]   mem_address;
    logic            mem_chipselect, mem_write, mem_clken;
    logic [LW/8-1:0] mem_byteenable;
    logic [LW-1:0]   mem_writedata;
    logic [LW-1:0]   mem_readdata = '0;
    logic            aes_in_valid;
    logic            aes_in_ready = 1'b0;
    logic [BW-1:0]   aes_in_data;
    logic            aes_out_valid = 1'b0;
    logic            aes_out_ready;
    logic [BW-1:0]   aes_out_data = '0;

    aes_line_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .num_lines(num_lines),
        .busy(busy), .done(done), .err(err),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_clken(mem_clken),
        .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready),
        .aes_in_data(aes_in_data),
        .aes_out_valid(aes_out_valid), .aes_out_ready(aes_out_ready),
        .aes_out_data(aes_out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] d;
        int            rt;
    } blk_t;

    logic [LW-1:0] mem     [NW];
    logic [LW-1:0] exp_mem [NW];
    blk_t          aq[$];
    logic [BW-1:0] exp_in[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            cs_cnt = 0;
    int            mode = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_mem(input string name);
        int bad = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk(bad == 0, name, bad, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        bit ok;
        ok = !busy && !done && !err && mem_address == '0
            && !mem_chipselect && !mem_write && mem_byteenable == '0
            && mem_writedata == '0 && !aes_in_valid && aes_in_data == '0
            && !aes_out_ready && mem_clken;
        chk(ok, name, {busy, done, err, mem_chipselect, mem_write,
                       aes_in_valid, aes_out_ready, mem_clken}, 8'h01);
    endtask

    // Memory, AES core and per-cycle stream checker.
    initial begin
        blk_t          b;
        bit            rd_pend = 0;
        logic [AW-1:0] rd_addr = '0;
        bit            stall_prev = 0;
        logic [BW-1:0] stall_data = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                aq.delete();
                stall_prev = 0;
                rd_pend = 0;
            end else begin
                if (mem_chipselect) begin
                    cs_cnt++;
                    chk(int'(mem_address) < NW, "addr_range", mem_address, NW-1);
                    chk(mem_byteenable == {(LW/8){mem_write}}, "byteenable",
                        mem_byteenable[127:0], {128{mem_write}});
                    if (mem_write) mem[mem_address] = mem_writedata;
                    else begin
                        rd_pend = 1;
                        rd_addr = mem_address;
                    end
                end
                if (stall_prev)
                    chk(aes_in_valid && aes_in_data == stall_data, "in_stable",
                        aes_in_data, stall_data);
                stall_prev = aes_in_valid && !aes_in_ready;
                stall_data = aes_in_data;
                if (aes_out_valid && aes_out_ready) aq.pop_front();
                if (aes_in_valid && aes_in_ready) begin
                    if (exp_in.size() == 0) chk(0, "in_extra", aes_in_data, 0);
                    else begin
                        chk(aes_in_data == exp_in[0], "in_data", aes_in_data, exp_in[0]);
                        void'(exp_in.pop_front());
                    end
                    b.d  = ~aes_in_data;
                    b.rt = cyc + 1 + (mode != 0 ? int'($urandom_range(0, 5)) : 0);
                    aq.push_back(b);
                end
            end
            @(negedge clk);
            if (rd_pend) begin
                mem_readdata = mem[rd_addr];
                rd_pend = 0;
            end
            aes_in_ready = (mode != 0) ? (cyc % 2 == 0) : 1'b1;
            if (aq.size() > 0 && aq[0].rt <= cyc + 1) begin
                aes_out_valid = 1'b1;
                aes_out_data  = aq[0].d;
            end else begin
                aes_out_valid = 1'b0;
                aes_out_data  = '0;
            end
        end
    end

    // Issues one command; the reference image commits `commit` lines.
    task automatic run_cmd(input int s, input int d, input int n,
                           input int commit, input int reset_at, input int extra_at,
                           output int busy_n, output int done_n,
                           output int done_t, output bit err_at_done);
        bit            got = 0;
        int            t;
        logic [LW-1:0] line;
        if (n != 0 && s + n <= NW && d + n <= NW) begin
            for (int i = 0; i < n; i++) begin
                line = exp_mem[s+i];
                for (int l = 0; l < LANES; l++) exp_in.push_back(line[l*BW +: BW]);
                if (i < commit) exp_mem[d+i] = ~line;
            end
        end
        @(negedge clk);
        src_addr  = AW'(s);
        dst_addr  = AW'(d);
        num_lines = AW'(n);
        start     = 1'b1;
        cs_cnt    = 0;
        busy_n = 0; done_n = 0; done_t = -1; err_at_done = 0;
        for (t = 0; t < 3000; t++) begin
            #1;
            if (reset_at > 0 && t == reset_at + 1) begin
                check_reset_outputs("reset_midrun");
                reset_n = 1'b1;
                exp_in.delete();
                got = 1;
                break;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (!got) begin
                    done_t = t;
                    err_at_done = err;
                end
                got = 1;
            end
            if (got && t >= done_t + 3) break;
            @(negedge clk);
            start = 1'b0;
            if (t + 1 == extra_at) begin
                start = 1'b1;
                src_addr = '0;
                dst_addr = AW'(1);
                num_lines = AW'(1);
            end
            if (reset_at > 0 && t + 1 == reset_at) reset_n = 1'b0;
        end
        if (!got) chk(0, "timeout", t, 0);
    endtask

    initial begin
        int            bn, dn, dt;
        bit            ea;
        logic [LW-1:0] p, orig;
        int            s, d, n;
        int            bad_s[3] = '{3600, 10, 0};
        int            bad_d[3] = '{0, 20, 3599};
        int            bad_n[3] = '{2, 0, 3};

        for (int i = 0; i < NW; i++) begin
            mem[i] = rnd_line();
            exp_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        // in-place single line, zero-stall core
        mode = 0;
        p = rnd_line();
        mem[5] = p;
        exp_mem[5] = p;
        run_cmd(5, 5, 1, 1, 0, 0, bn, dn, dt, ea);
        chk(bn == 15, "inplace_busy", bn, 15);
        chk(dn == 1, "inplace_done_cnt", dn, 1);
        chk(dt == 15, "inplace_done_time", dt, 15);
        chk(!ea, "inplace_err", ea, 0);
        chk(mem[5] === ~p, "inplace_line", mem[5][127:0], ~p[127:0]);
        check_mem("inplace_mem");

        // four lines with backpressure and random core latency
        mode = 1;
        orig = mem[3];
        run_cmd(0, 100, 4, 4, 0, 0, bn, dn, dt, ea);
        chk(dn == 1, "multi_done_cnt", dn, 1);
        chk(!ea, "multi_err", ea, 0);
        chk(mem[103] === ~orig, "multi_line3", mem[103][127:0], ~orig[127:0]);
        check_mem("multi_mem");

        // range errors
        mode = 0;
        for (int k = 0; k < 3; k++) begin
            run_cmd(bad_s[k], bad_d[k], bad_n[k], 0, 0, 0, bn, dn, dt, ea);
            chk(ea, "rangeerr_err", ea, 1);
            chk(dt == 2, "rangeerr_done_time", dt, 2);
            chk(dn == 1, "rangeerr_done_cnt", dn, 1);
            chk(bn == 2, "rangeerr_busy", bn, 2);
            chk(cs_cnt == 0, "rangeerr_no_mem", cs_cnt, 0);
        end
        chk(err, "err_sticky", err, 1);
        check_mem("rangeerr_mem");

        // last legal source line
        orig = mem[3600];
        run_cmd(3600, 0, 1, 1, 0, 0, bn, dn, dt, ea);
        chk(!ea, "boundary_err", ea, 0);
        chk(dn == 1, "boundary_done_cnt", dn, 1);
        chk(mem[0] === ~orig, "boundary_line", mem[0][127:0], ~orig[127:0]);
        check_mem("boundary_mem");

        // start pulse while busy is ignored; the run clears a previous err
        run_cmd(0, 0, 0, 0, 0, 0, bn, dn, dt, ea);
        chk(ea, "preerr_err", ea, 1);
        run_cmd(400, 500, 2, 2, 0, 20, bn, dn, dt, ea);
        chk(!ea, "ignore_err_cleared", ea, 0);
        chk(bn == 28, "ignore_busy", bn, 28);
        chk(dn == 1, "ignore_done_cnt", dn, 1);
        check_mem("ignore_mem");

        // reset while streaming the second of four lines
        run_cmd(200, 300, 4, 1, 20, 0, bn, dn, dt, ea);
        chk(dn == 0, "reset_no_done", dn, 0);
        check_mem("reset_mem");

        // random legal commands, possibly overlapping
        for (int k = 0; k < 6; k++) begin
            mode = int'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            s = int'($urandom_range(0, NW - n));
            d = (k % 2 == 0) ? s + int'($urandom_range(0, 1)) : int'($urandom_range(0, NW - n));
            if (d + n > NW) d = NW - n;
            run_cmd(s, d, n, n, 0, 0, bn, dn, dt, ea);
            chk(dn == 1 && !ea, "rand_done", {dn[7:0], 7'b0, ea}, 16'h0100);
            if (mode == 0) chk(bn == 13 * n + 2, "rand_busy", bn, 13 * n + 2);
            check_mem("rand_mem");
        end
        chk(exp_in.size() == 0, "in_leftover", exp_in.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
